fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DWIDTH, default 8, data word width.
REQ-002 Parameter AWIDTH, default 4, downstream FIFO address width; DEPTH = 2**AWIDTH.
REQ-003 Parameter NUM_REQ, default 4, number of requesters, range 2..16.
REQ-004 Parameter BURST_LEN, default 4, maximum beats per grant, range 1..255.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 req_valid_i  in  NUM_REQ  per-requester word valid.
REQ-008 req_data_i  in  NUM_REQ*DWIDTH  per-requester word; requester k owns bits [k*DWIDTH +: DWIDTH].
REQ-009 req_ready_o  out  NUM_REQ  per-requester accept; transfer = valid & ready in the same cycle.
REQ-010 grant_o  out  NUM_REQ  one-hot or zero; current owner of the FIFO write port.
REQ-011 busy_o  out  1  high while a grant is held.
REQ-012 fifo_wrreq_o  out  1  registered write strobe to the FIFO.
REQ-013 fifo_data_o  out  DWIDTH  registered write data to the FIFO.
REQ-014 fifo_full_i  in  1  FIFO full flag.
REQ-015 fifo_usedw_i  in  AWIDTH  FIFO used-words count; wraps to 0 when full.

Function
REQ-016 FSM states: IDLE (grant_o = 0) and GRANT (exactly one grant_o bit set); busy_o = (state == GRANT).
REQ-017 Arbitration is round-robin: search starts at the index after the last granted requester and wraps to 0.
REQ-018 IDLE -> GRANT on the first edge where any req_valid_i is high; the selected requester's grant_o is high in the next cycle.
REQ-019 Space check: occupancy = fifo_full_i ? DEPTH : fifo_usedw_i; space_ok = (occupancy + fifo_wrreq_o) < DEPTH.
REQ-020 req_ready_o[k] = grant_o[k] & space_ok, combinational; all other ready bits are 0.
REQ-021 On a transfer, fifo_wrreq_o = 1 and fifo_data_o = that requester's word on the next cycle; otherwise fifo_wrreq_o = 0 and fifo_data_o holds.
REQ-022 A beat counter counts transfers within a grant, clears on every new grant and never exceeds BURST_LEN.
REQ-023 A grant is released at the edge where (a) the BURST_LEN-th beat transfers, or (b) req_valid_i of the owner is low.
REQ-024 On release, re-arbitration happens at the same edge: if any requester is valid, the new grant is active next cycle with no idle cycle; otherwise -> IDLE.
REQ-025 A requester released by burst expiry that is still valid competes at lowest priority; if it is the only valid requester, it is re-granted immediately.
REQ-026 A stall caused by !space_ok does not release the grant and does not advance the beat counter.
REQ-027 The block never issues a write that would push occupancy above DEPTH.
REQ-028 Data order per requester is preserved; words are never duplicated or dropped.

Reset
REQ-029 While rst_i = 1: state = IDLE, grant_o = 0, req_ready_o = 0, busy_o = 0, fifo_wrreq_o = 0, fifo_data_o = 0, beat counter = 0.
REQ-030 After reset, the round-robin pointer gives requester 0 highest priority.
REQ-031 rst_i asserted mid-burst clears outputs immediately, without a clock edge; the word in flight is not written.

Verification
REQ-032 Req0 valid with 6 words, FIFO empty, no reads -> grant_o = 0001 one cycle after valid; 4 beats, then re-granted with no gap; 6 wrreq pulses in order, each one cycle after its handshake.
REQ-033 All 4 requesters continuously valid -> grants 0001, 0010, 0100, 1000, 0001, each 4 beats, zero idle cycles between grants.
REQ-034 Req1 streams 20 words with no FIFO reads -> exactly 16 writes; ready drops once occupancy + pending = 16; no write while full_i = 1; one external read lets exactly one more transfer through.
REQ-035 Req2 granted, valid drops after 2 beats while req3 is valid -> grant moves to 1000 on the next cycle; beat counter restarts at 0.
REQ-036 rst_i pulsed asynchronously mid-burst -> grant_o, req_ready_o and fifo_wrreq_o go to 0 before the next edge; after release, req0 has priority.
REQ-037 Last grant 1000, req0 and req3 both valid at release -> next grant 0001.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester-side and FIFO-side signals around the write arbiter.
// Signal suffixes are from the arbiter's point of view; the arbiter uses the master modport.
interface fifo_wr_arbiter_if #(
   parameter int DWIDTH  = 8,
   parameter int AWIDTH  = 4,
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]        req_valid_i;
   logic [NUM_REQ*DWIDTH-1:0] req_data_i;
   logic [NUM_REQ-1:0]        req_ready_o;
   logic [NUM_REQ-1:0]        grant_o;
   logic                      busy_o;
   logic                      fifo_wrreq_o;
   logic [DWIDTH-1:0]         fifo_data_o;
   logic                      fifo_full_i;
   logic [AWIDTH-1:0]         fifo_usedw_i;

   modport master (
      input  req_valid_i,
      input  req_data_i,
      input  fifo_full_i,
      input  fifo_usedw_i,
      output req_ready_o,
      output grant_o,
      output busy_o,
      output fifo_wrreq_o,
      output fifo_data_o
   );

   modport slave (
      output req_valid_i,
      output req_data_i,
      output fifo_full_i,
      output fifo_usedw_i,
      input  req_ready_o,
      input  grant_o,
      input  busy_o,
      input  fifo_wrreq_o,
      input  fifo_data_o
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one of NUM_REQ requesters bursts of up to BURST_LEN
// words into a single downstream FIFO write port, never overfilling the FIFO.
//
// state   | meaning
// S_IDLE  | no owner, grant_o = 0, waiting for any req_valid_i
// S_GRANT | one requester owns the write port (grant_o one-hot)
module fifo_wr_arbiter #(
   parameter int DWIDTH    = 8,
   parameter int AWIDTH    = 4,
   parameter int NUM_REQ   = 4,
   parameter int BURST_LEN = 4
) (
   input logic              clk_i,
   input logic              rst_i,
   fifo_wr_arbiter_if.master bus
);

   localparam int DEPTH = 1 << AWIDTH;
   localparam int IDXW  = $clog2(NUM_REQ);
   localparam int OCCW  = AWIDTH + 2;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t              state_q;
   logic [NUM_REQ-1:0]  grant_q;
   logic [IDXW-1:0]     owner_q;
   logic [IDXW-1:0]     last_q;
   logic [7:0]          beat_q;
   logic                wrreq_q;
   logic [DWIDTH-1:0]   data_q;

   logic [OCCW-1:0]     occ;
   logic                space_ok;
   logic [NUM_REQ-1:0]  ready;
   logic                owner_valid;
   logic [DWIDTH-1:0]   owner_word;
   logic                xfer;
   logic                last_beat;
   logic                rel_grant;
   logic                pick_found;
   logic [IDXW-1:0]     pick_idx;
   logic [IDXW-1:0]     cand;
   logic [NUM_REQ-1:0]  grant_d;

   // The pending registered write is counted so a word already on its way
   // to the FIFO is never forgotten when judging free space.
   assign occ      = (bus.fifo_full_i ? OCCW'(DEPTH) : OCCW'(bus.fifo_usedw_i))
                     + OCCW'(wrreq_q);
   assign space_ok = occ < OCCW'(DEPTH);
   assign ready    = grant_q & {NUM_REQ{space_ok}};

   assign owner_valid = bus.req_valid_i[owner_q];
   assign xfer        = |(bus.req_valid_i & ready);
   assign last_beat   = beat_q == 8'(BURST_LEN - 1);
   assign rel_grant   = (state_q == S_GRANT) && (!owner_valid || (xfer && last_beat));

   always_comb begin
      owner_word = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (IDXW'(k) == owner_q) begin
            owner_word = bus.req_data_i[k*DWIDTH +: DWIDTH];
         end
      end
   end

   // Search starts just after the last owner, so that owner ends up lowest priority.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDXW'((int'(last_q) + i) % NUM_REQ);
         if (!pick_found && bus.req_valid_i[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   assign grant_d = NUM_REQ'(1) << pick_idx;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         owner_q <= '0;
         last_q  <= IDXW'(NUM_REQ - 1);
         beat_q  <= '0;
         wrreq_q <= 1'b0;
         data_q  <= '0;
      end else begin
         wrreq_q <= xfer;
         if (xfer) begin
            data_q <= owner_word;
         end
         case (state_q)
            S_IDLE: begin
               if (pick_found) begin
                  state_q <= S_GRANT;
                  grant_q <= grant_d;
                  owner_q <= pick_idx;
                  last_q  <= pick_idx;
                  beat_q  <= '0;
               end
            end
            S_GRANT: begin
               if (rel_grant) begin
                  if (pick_found) begin
                     grant_q <= grant_d;
                     owner_q <= pick_idx;
                     last_q  <= pick_idx;
                     beat_q  <= '0;
                  end else begin
                     state_q <= S_IDLE;
                     grant_q <= '0;
                     beat_q  <= '0;
                  end
               end else if (xfer) begin
                  beat_q <= beat_q + 8'd1;
               end
            end
         endcase
      end
   end

   assign bus.req_ready_o  = ready;
   assign bus.grant_o      = grant_q;
   assign bus.busy_o       = (state_q == S_GRANT);
   assign bus.fifo_wrreq_o = wrreq_q;
   assign bus.fifo_data_o  = data_q;

endmodule
